// File: rtl/part_74ls169.sv
// Synchronous presettable up/down binary counter with active-low ripple carry (74LS169).
// Latency: one CLK from load/enable sampling to Q; RCO_N is combinational from ENT_N, U_D, Q.
// No backpressure: ENP_N/ENT_N gate counting; LS169_SYNC_CLEAR_EN adds synchronous clear CLR_N.
`default_nettype none

module part_74ls169 #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD_N,
    input  logic             ENP_N,
    input  logic             ENT_N,
    input  logic             U_D,
`ifdef LS169_SYNC_CLEAR_EN
    input  logic             CLR_N,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO_N
);

    logic             cnt_en;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             at_term;

    assign cnt_en  = ~ENP_N & ~ENT_N;
    assign cnt_nxt = U_D ? (Q + 1'b1) : (Q - 1'b1);

    // Ternaries rather than if/else so an X on a control input merges into Q in simulation.
`ifdef LS169_SYNC_CLEAR_EN
    assign q_nxt = !CLR_N ? '0 : (!LOAD_N ? D : (cnt_en ? cnt_nxt : Q));
`else
    assign q_nxt = !LOAD_N ? D : (cnt_en ? cnt_nxt : Q);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            Q <= '0;
        else
            Q <= q_nxt;
    end

    // Terminal value depends on direction: all-ones counting up, zero counting down.
    assign at_term = U_D ? (&Q) : ~(|Q);
    assign RCO_N   = ~(~ENT_N & at_term);

endmodule

`default_nettype wire

// File: tb/tb_part_74ls169.sv
// Scoreboard bench for part_74ls169: stimulus queues expected Q/RCO_N, a monitor compares.
`timescale 1ns/1ps

module tb_part_74ls169;

    typedef struct {
        string      name;
        bit         sel;   // 0 = single counter, 1 = 8-bit cascade
        logic [7:0] q;
        logic       rco;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   checks   = 0;
    int   failures = 0;

    logic       CLK = 1'b0;
    logic       RESET, LOAD_N, ENP_N, ENT_N, U_D, CLR_N;
    logic [3:0] D;
    logic [3:0] Q;
    logic       RCO_N;

    logic       c_load_n, c_u_d;
    logic [7:0] c_d;
    logic [3:0] cl_q, cu_q;
    logic       cl_rco_n, cu_rco_n;

    always #5 CLK = ~CLK;

    part_74ls169 #(.WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .LOAD_N(LOAD_N), .ENP_N(ENP_N), .ENT_N(ENT_N), .U_D(U_D),
`ifdef LS169_SYNC_CLEAR_EN
        .CLR_N(CLR_N),
`endif
        .D(D), .Q(Q), .RCO_N(RCO_N)
    );

    part_74ls169 #(.WIDTH(4)) u_lo (
        .CLK(CLK), .RESET(RESET), .LOAD_N(c_load_n), .ENP_N(1'b0), .ENT_N(1'b0), .U_D(c_u_d),
`ifdef LS169_SYNC_CLEAR_EN
        .CLR_N(1'b1),
`endif
        .D(c_d[3:0]), .Q(cl_q), .RCO_N(cl_rco_n)
    );

    part_74ls169 #(.WIDTH(4)) u_hi (
        .CLK(CLK), .RESET(RESET), .LOAD_N(c_load_n), .ENP_N(1'b0), .ENT_N(cl_rco_n), .U_D(c_u_d),
`ifdef LS169_SYNC_CLEAR_EN
        .CLR_N(1'b1),
`endif
        .D(c_d[7:4]), .Q(cu_q), .RCO_N(cu_rco_n)
    );

    // Monitor: drains the scoreboard whenever stimulus says outputs are presented.
    initial begin
        exp_t       e;
        logic [7:0] act_q;
        logic       act_r;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e     = sb.pop_front();
                act_q = e.sel ? {cu_q, cl_q} : {4'h0, Q};
                act_r = e.sel ? cu_rco_n : RCO_N;
                checks++;
                if (act_q !== e.q || act_r !== e.rco) begin
                    failures++;
                    $display("FAIL %s: got Q=%h RCO_N=%b, want Q=%h RCO_N=%b",
                             e.name, act_q, act_r, e.q, e.rco);
                end
            end
        end
    end

    task automatic push(input string nm, input bit sel, input logic [7:0] q, input logic r);
        exp_t e;
        e.name = nm; e.sel = sel; e.q = q; e.rco = r;
        sb.push_back(e);
        #1;
        -> chk_ev;
        #1;
    endtask

    // Expectation after the next rising edge; returns at the following falling edge.
    task automatic edge_chk(input string nm, input logic [3:0] q, input logic r);
        @(posedge CLK);
        #1;
        push(nm, 1'b0, {4'h0, q}, r);
        @(negedge CLK);
    endtask

    // Expectation with no clock edge (async reset or combinational RCO_N).
    task automatic now_chk(input string nm, input logic [3:0] q, input logic r);
        push(nm, 1'b0, {4'h0, q}, r);
    endtask

    task automatic casc_chk(input string nm, input logic [7:0] q, input logic r);
        @(posedge CLK);
        #1;
        push(nm, 1'b1, q, r);
        @(negedge CLK);
    endtask

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, want finish before 50000ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; LOAD_N = 1'b1; ENP_N = 1'b1; ENT_N = 1'b1; U_D = 1'b1; D = 4'h0;
        CLR_N = 1'b1; c_load_n = 1'b1; c_u_d = 1'b1; c_d = 8'h00;
        now_chk("reset_q0_ent_hi", 4'h0, 1'b1);
        ENT_N = 1'b0; U_D = 1'b0;
        now_chk("reset_rco_down", 4'h0, 1'b0);
        @(negedge CLK);

        // Load 9, then assert reset mid-count without an edge
        RESET = 1'b0; LOAD_N = 1'b0; D = 4'h9; ENP_N = 1'b0; ENT_N = 1'b0; U_D = 1'b1;
        edge_chk("load_9", 4'h9, 1'b1);
        LOAD_N = 1'b1;
        RESET = 1'b1;
        now_chk("reset_async", 4'h0, 1'b1);
        edge_chk("reset_held_edge", 4'h0, 1'b1);
        RESET = 1'b0;
        edge_chk("reset_release_cnt", 4'h1, 1'b1);

        // Load priority over counting down
        LOAD_N = 1'b0; D = 4'h3;
        edge_chk("load_3", 4'h3, 1'b1);
        D = 4'hA; U_D = 1'b0;
        edge_chk("load_prio_A", 4'hA, 1'b1);
        LOAD_N = 1'b1;
        edge_chk("down_to_9", 4'h9, 1'b1);

        // Up wrap from D
        LOAD_N = 1'b0; D = 4'hD; U_D = 1'b1;
        edge_chk("load_D", 4'hD, 1'b1);
        LOAD_N = 1'b1;
        edge_chk("up_E", 4'hE, 1'b1);
        edge_chk("up_F_rco", 4'hF, 1'b0);
        ENT_N = 1'b1;
        now_chk("F_ent_hi_rco", 4'hF, 1'b1);
        ENT_N = 1'b0;
        edge_chk("up_wrap_0", 4'h0, 1'b1);

        // Down wrap from 1
        LOAD_N = 1'b0; D = 4'h1; U_D = 1'b0;
        edge_chk("load_1", 4'h1, 1'b1);
        LOAD_N = 1'b1;
        edge_chk("down_0_rco", 4'h0, 1'b0);
        U_D = 1'b1;
        now_chk("flip_up_rco", 4'h0, 1'b1);
        U_D = 1'b0;
        edge_chk("down_wrap_F", 4'hF, 1'b1);

        // Enable gating
        ENP_N = 1'b1;
        for (int i = 0; i < 5; i++)
            edge_chk("enp_hold", 4'hF, 1'b1);
        U_D = 1'b1;
        now_chk("rco_ignores_enp", 4'hF, 1'b0);
        ENP_N = 1'b0; ENT_N = 1'b1;
        edge_chk("ent_hold", 4'hF, 1'b1);
        edge_chk("ent_hold2", 4'hF, 1'b1);

`ifdef LS169_SYNC_CLEAR_EN
        ENT_N = 1'b0; LOAD_N = 1'b0; D = 4'h5; CLR_N = 1'b0;
        edge_chk("clr_over_load", 4'h0, 1'b1);
        CLR_N = 1'b1;
        edge_chk("load_after_clr", 4'h5, 1'b1);
        LOAD_N = 1'b1;
`endif

        // Cascade: two stages as an 8-bit counter
        c_load_n = 1'b0; c_d = 8'h0E; c_u_d = 1'b1;
        casc_chk("casc_load_0E", 8'h0E, 1'b1);
        c_load_n = 1'b1;
        casc_chk("casc_0F", 8'h0F, 1'b1);
        casc_chk("casc_10", 8'h10, 1'b1);
        casc_chk("casc_11", 8'h11, 1'b1);
        c_u_d = 1'b0;
        casc_chk("casc_down_10", 8'h10, 1'b1);
        casc_chk("casc_down_0F", 8'h0F, 1'b1);

        #5;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
